// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//
// Main sequencing controller for the multicycle ARM datapath with extended
// multiply/divide.  A Moore FSM walks each instruction through fetch, decode,
// execute, memory and writeback.  Multiply/divide instructions wait in MDWAIT
// for a parameterised number of cycles.  Long multiplies take an extra
// writeback cycle (ALUWB2) that stores the high result word.
//
// Parameters
//   MUL_LAT  total execute cycles for multiply-class ops (>= 1)
//   DIV_LAT  total execute cycles for divide ops (>= 1)
//   CNT_W    latency counter width, max(MUL_LAT,DIV_LAT)-2 < 2**CNT_W
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   Op         in   instruction op class (from the instruction register)
//   Funct      in   instruction funct field
//   Long       in   op writes a 64-bit result
//   NoWrite    in   compare/test op, no register writeback
//   IRWrite    out  instruction register load
//   NextPC     out  PC <- PC+4
//   AdrSrc     out  memory address source, 0=PC 1=ALU result
//   ALUSrcA    out  0=register A 1=PC
//   ALUSrcB    out  00=register B 01=extended immediate 10=constant 4
//   ResultSrc  out  00=ALUOut 01=read data 10=ALU result
//   ALUOp      out  use decoded ALUControl (else ADD)
//   RegW       out  register-file write (before condition gating)
//   MemW       out  memory write (before condition gating)
//   Branch     out  branch cycle
//   HiSel      out  writeback selects the high result word
//   MdStart    out  one-cycle start pulse to the multiply/divide unit
//   MdBusy     out  multiply/divide in progress
//   State      out  current state encoding (debug)
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
    parameter int MUL_LAT = 2,
    parameter int DIV_LAT = 34,
    parameter int CNT_W   = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic       Long,
    input  logic       NoWrite,
    output logic       IRWrite,
    output logic       NextPC,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       ALUOp,
    output logic       RegW,
    output logic       MemW,
    output logic       Branch,
    output logic       HiSel,
    output logic       MdStart,
    output logic       MdBusy,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9,
        MDWAIT = 4'd10,
        ALUWB2 = 4'd11
    } state_t;

    // Counter preload values; the EXECR cycle and the final MDWAIT cycle
    // (cnt=0) together account for the 2 subtracted here.
    localparam logic [CNT_W-1:0] MUL_LOAD =
        (MUL_LAT >= 2) ? CNT_W'(MUL_LAT - 2) : {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] DIV_LOAD =
        (DIV_LAT >= 2) ? CNT_W'(DIV_LAT - 2) : {CNT_W{1'b0}};
    localparam logic MUL_ONE = (MUL_LAT == 1);
    localparam logic DIV_ONE = (DIV_LAT == 1);

    // State kept as a plain vector so that encodings 12-15 are representable
    // and can be recovered from.
    logic [3:0]       state_r;
    logic [3:0]       next_state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic             is_md_s;
    logic             is_div_s;
    logic             lat_one_s;
    logic [CNT_W-1:0] lat_load_s;

    // Op-class decode for the multiply/divide latency selection.
    always_comb begin
        is_md_s  = (Op == 2'b11);
        is_div_s = (Funct[4:1] == 4'b0111) || (Funct[4:1] == 4'b1000);
        if (is_div_s) begin
            lat_one_s  = DIV_ONE;
            lat_load_s = DIV_LOAD;
        end else begin
            lat_one_s  = MUL_ONE;
            lat_load_s = MUL_LOAD;
        end
    end

    // State and latency counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= FETCH;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= next_state_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Next-state and counter update logic.
    always_comb begin
        next_state_s = FETCH;
        cnt_next_s   = cnt_r;
        case (state_r)
            FETCH: next_state_s = DECODE;
            DECODE: begin
                case (Op)
                    2'b01:   next_state_s = MEMADR;
                    2'b10:   next_state_s = BRANCH;
                    2'b00:   next_state_s = Funct[5] ? EXECI : EXECR;
                    2'b11:   next_state_s = EXECR;
                    default: next_state_s = FETCH;
                endcase
            end
            MEMADR: next_state_s = Funct[0] ? MEMRD : MEMWR;
            MEMRD:  next_state_s = MEMWB;
            MEMWB:  next_state_s = FETCH;
            MEMWR:  next_state_s = FETCH;
            BRANCH: next_state_s = FETCH;
            EXECI:  next_state_s = ALUWB;
            EXECR: begin
                if (is_md_s && !lat_one_s) begin
                    next_state_s = MDWAIT;
                    cnt_next_s   = lat_load_s;
                end else begin
                    next_state_s = ALUWB;
                end
            end
            MDWAIT: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    next_state_s = ALUWB;
                end else begin
                    next_state_s = MDWAIT;
                    cnt_next_s   = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ALUWB:  next_state_s = Long ? ALUWB2 : FETCH;
            ALUWB2: next_state_s = FETCH;
            default: next_state_s = FETCH;
        endcase
    end

    // Moore output decode; MdStart additionally looks at Op in EXECR and
    // RegW at NoWrite in ALUWB.
    always_comb begin
        IRWrite   = 1'b0;
        NextPC    = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        ALUOp     = 1'b0;
        RegW      = 1'b0;
        MemW      = 1'b0;
        Branch    = 1'b0;
        HiSel     = 1'b0;
        MdStart   = 1'b0;
        MdBusy    = 1'b0;
        State     = state_r;
        case (state_r)
            FETCH: begin
                IRWrite   = 1'b1;
                NextPC    = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            MEMADR: ALUSrcB = 2'b01;
            MEMRD:  AdrSrc  = 1'b1;
            MEMWB: begin
                ResultSrc = 2'b01;
                RegW      = 1'b1;
            end
            MEMWR: begin
                AdrSrc = 1'b1;
                MemW   = 1'b1;
            end
            EXECR: begin
                ALUOp   = 1'b1;
                MdStart = is_md_s;
            end
            EXECI: begin
                ALUSrcB = 2'b01;
                ALUOp   = 1'b1;
            end
            MDWAIT: begin
                ALUOp  = 1'b1;
                MdBusy = 1'b1;
            end
            ALUWB:  RegW = ~NoWrite;
            ALUWB2: begin
                RegW  = 1'b1;
                HiSel = 1'b1;
            end
            BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                Branch    = 1'b1;
            end
            default: begin
                IRWrite = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
//
// Directed bench for multicycle_ctrl.  For each instruction the expected
// per-cycle output bundle (all outputs plus State) is built from the state
// sequence the controller should follow and pushed to a scoreboard queue;
// the queue is then drained one entry per clock, sampled at the falling edge.
// A second instance with MUL_LAT=3, DIV_LAT=1 covers the single-cycle divide
// and a longer multiply.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rst2_n;
    logic [1:0] op;
    logic [5:0] funct;
    logic       lng;
    logic       nowrite;

    logic       irw1, npc1, adr1, asa1, alop1, rw1, mw1, br1, hi1, mds1, mdb1;
    logic [1:0] asb1, rs1;
    logic [3:0] st1;
    logic       irw2, npc2, adr2, asa2, alop2, rw2, mw2, br2, hi2, mds2, mdb2;
    logic [1:0] asb2, rs2;
    logic [3:0] st2;

    logic [18:0] b1, b2;
    logic [18:0] sb_q[$];
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk(clk), .reset(rst_n), .Op(op), .Funct(funct), .Long(lng), .NoWrite(nowrite),
        .IRWrite(irw1), .NextPC(npc1), .AdrSrc(adr1), .ALUSrcA(asa1), .ALUSrcB(asb1),
        .ResultSrc(rs1), .ALUOp(alop1), .RegW(rw1), .MemW(mw1), .Branch(br1),
        .HiSel(hi1), .MdStart(mds1), .MdBusy(mdb1), .State(st1)
    );

    multicycle_ctrl #(.MUL_LAT(3), .DIV_LAT(1), .CNT_W(6)) dut2 (
        .clk(clk), .reset(rst2_n), .Op(op), .Funct(funct), .Long(lng), .NoWrite(nowrite),
        .IRWrite(irw2), .NextPC(npc2), .AdrSrc(adr2), .ALUSrcA(asa2), .ALUSrcB(asb2),
        .ResultSrc(rs2), .ALUOp(alop2), .RegW(rw2), .MemW(mw2), .Branch(br2),
        .HiSel(hi2), .MdStart(mds2), .MdBusy(mdb2), .State(st2)
    );

    assign b1 = {irw1, npc1, adr1, asa1, asb1, rs1, alop1, rw1, mw1, br1, hi1, mds1, mdb1, st1};
    assign b2 = {irw2, npc2, adr2, asa2, asb2, rs2, alop2, rw2, mw2, br2, hi2, mds2, mdb2, st2};

    // Expected output bundle for a state, from the controller's output table.
    function automatic logic [18:0] exp_out(input logic [3:0] s, input logic [1:0] o,
                                            input logic nw);
        logic irw, npc, adr, asa, alop, rw, mw, br, hi, mds, mdb;
        logic [1:0] asb, rs;
        {irw, npc, adr, asa, alop, rw, mw, br, hi, mds, mdb} = 11'b0;
        asb = 2'b00;
        rs  = 2'b00;
        case (s)
            4'd0:  begin irw = 1'b1; npc = 1'b1; asa = 1'b1; asb = 2'b10; rs = 2'b10; end
            4'd1:  begin asa = 1'b1; asb = 2'b10; rs = 2'b10; end
            4'd2:  asb = 2'b01;
            4'd3:  adr = 1'b1;
            4'd4:  begin rs = 2'b01; rw = 1'b1; end
            4'd5:  begin adr = 1'b1; mw = 1'b1; end
            4'd6:  begin alop = 1'b1; mds = (o == 2'b11); end
            4'd7:  begin asb = 2'b01; alop = 1'b1; end
            4'd8:  rw = ~nw;
            4'd9:  begin asb = 2'b01; rs = 2'b10; br = 1'b1; end
            4'd10: begin alop = 1'b1; mdb = 1'b1; end
            4'd11: begin rw = 1'b1; hi = 1'b1; end
            default: irw = 1'b0;
        endcase
        return {irw, npc, adr, asa, asb, rs, alop, rw, mw, br, hi, mds, mdb, s};
    endfunction

    task automatic push_state(input logic [3:0] s);
        sb_q.push_back(exp_out(s, op, nowrite));
    endtask

    // Drive an instruction (call at a falling edge while in FETCH) and queue
    // its expected cycle-by-cycle outputs; lat is the execute latency of the
    // instance being checked.
    task automatic issue(input logic [1:0] o, input logic [5:0] f, input logic l,
                         input logic nw, input int lat);
        op = o; funct = f; lng = l; nowrite = nw;
        push_state(4'd0);
        push_state(4'd1);
        case (o)
            2'b01: begin
                push_state(4'd2);
                if (f[0]) begin
                    push_state(4'd3);
                    push_state(4'd4);
                end else begin
                    push_state(4'd5);
                end
            end
            2'b10: push_state(4'd9);
            2'b00: begin
                push_state(f[5] ? 4'd7 : 4'd6);
                push_state(4'd8);
                if (l) push_state(4'd11);
            end
            default: begin
                push_state(4'd6);
                for (int i = 0; i < lat - 1; i++) push_state(4'd10);
                push_state(4'd8);
                if (l) push_state(4'd11);
            end
        endcase
    endtask

    task automatic check(input string tag, input logic [18:0] obs, input logic [18:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Pop and compare up to n entries (n<0: drain the queue), one per cycle.
    task automatic run(input string tag, input bit use2, input int n);
        int k = 0;
        logic [18:0] e;
        while (sb_q.size() > 0 && (n < 0 || k < n)) begin
            e = sb_q.pop_front();
            check($sformatf("%s[%0d]", tag, k), use2 ? b2 : b1, e);
            k++;
            @(negedge clk);
        end
    endtask

    initial begin
        logic [18:0] e;
        op = 2'b00; funct = 6'b000000; lng = 1'b0; nowrite = 1'b0;
        rst_n = 1'b0; rst2_n = 1'b0;
        #1;
        check("reset_fetch", b1, exp_out(4'd0, 2'b00, 1'b0));
        @(negedge clk);
        check("reset_hold", b1, exp_out(4'd0, 2'b00, 1'b0));
        rst_n = 1'b1;

        issue(2'b00, 6'b001000, 1'b0, 1'b0, 2);  run("add", 1'b0, -1);
        issue(2'b00, 6'b010101, 1'b0, 1'b1, 2);  run("cmp", 1'b0, -1);
        issue(2'b00, 6'b101000, 1'b0, 1'b0, 2);  run("addimm", 1'b0, -1);
        issue(2'b01, 6'b011001, 1'b0, 1'b0, 2);  run("ldr", 1'b0, -1);
        issue(2'b01, 6'b011000, 1'b0, 1'b0, 2);  run("str", 1'b0, -1);
        issue(2'b10, 6'b000000, 1'b0, 1'b0, 2);  run("b", 1'b0, -1);
        issue(2'b11, 6'b000000, 1'b0, 1'b0, 2);  run("mul", 1'b0, -1);
        issue(2'b11, 6'b001000, 1'b1, 1'b0, 2);  run("umull", 1'b0, -1);
        issue(2'b11, 6'b001110, 1'b0, 1'b0, 34); run("div0111", 1'b0, -1);
        issue(2'b11, 6'b010000, 1'b0, 1'b0, 34); run("div1000", 1'b0, -1);
        check("after_div_fetch", b1, exp_out(4'd0, 2'b11, 1'b0));

        // Reset during the 10th MDWAIT cycle aborts without a RegW pulse.
        issue(2'b11, 6'b001110, 1'b0, 1'b0, 34);
        run("div_abort", 1'b0, 12);
        e = sb_q.pop_front();
        check("div_abort_mdwait10", b1, e);
        sb_q.delete();
        rst_n = 1'b0;
        #1;
        check("async_reset_fetch", b1, exp_out(4'd0, 2'b11, 1'b0));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_no_regw", b1, exp_out(4'd0, 2'b11, 1'b0));
        end
        rst_n = 1'b1;
        issue(2'b00, 6'b001000, 1'b0, 1'b0, 2);  run("add_after_abort", 1'b0, -1);

        // Illegal encoding recovers to FETCH on the next edge.
        force dut.state_r = 4'd13;
        #1;
        check("illegal_13_outputs", b1, exp_out(4'd13, op, nowrite));
        release dut.state_r;
        @(negedge clk);
        check("illegal_to_fetch", b1, exp_out(4'd0, op, nowrite));

        // Second instance: DIV_LAT=1 and MUL_LAT=3.
        rst2_n = 1'b1;
        issue(2'b11, 6'b001110, 1'b0, 1'b0, 1);  run("div_lat1", 1'b1, -1);
        issue(2'b11, 6'b000000, 1'b1, 1'b0, 3);  run("mul_lat3_long", 1'b1, -1);
        check("dut2_idle_fetch", b2, exp_out(4'd0, op, nowrite));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
